// File: rtl/pulse_deliver_pkg.sv
// Shared encodings and limits for the multi-channel req/ack pulse deliverer.
package pulse_deliver_pkg;

   localparam int TX_IDLE_BIT       = 0;
   localparam int TX_WAIT_ACK_H_BIT = 1;
   localparam int TX_WAIT_ACK_L_BIT = 2;

   localparam int RX_IDLE_BIT       = 0;
   localparam int RX_WAIT_REQ_L_BIT = 1;

   localparam int SYNC_STG_MIN = 2;
   localparam int SYNC_STG_MAX = 4;

   typedef enum logic [2:0] {
      TX_IDLE       = 3'(1 << TX_IDLE_BIT),
      TX_WAIT_ACK_H = 3'(1 << TX_WAIT_ACK_H_BIT),
      TX_WAIT_ACK_L = 3'(1 << TX_WAIT_ACK_L_BIT)
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE       = 2'(1 << RX_IDLE_BIT),
      RX_WAIT_REQ_L = 2'(1 << RX_WAIT_REQ_L_BIT)
   } rx_state_e;

endpackage

// File: rtl/cdc_synczr.sv
// Single-bit multi-flop synchronizer cell; output resets low.
module cdc_synczr #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_deliver_ch.sv
// One channel: pending-event counter and TX handshake FSM in clk_a,
// RX FSM emitting one clk_b pulse per completed request.
module pulse_deliver_ch
   import pulse_deliver_pkg::*;
#(
   parameter int CNT_W    = 4,
   parameter int SYNC_STG = 2
) (
   input  logic clk_a_i,
   input  logic rst_a_n_i,
   input  logic clk_b_i,
   input  logic rst_b_n_i,
   input  logic pulse_i,
   input  logic ovf_clr_i,
   output logic pulse_o,
   output logic busy_o,
   output logic ovf_o
);

   localparam logic [CNT_W-1:0] PEND_MAX = '1;

   tx_state_e        tx_q, tx_d;
   logic             req_q, req_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             ovf_q, ovf_d;
   logic             launch;
   logic             ack_sync;

   rx_state_e        rx_q, rx_d;
   logic             ack_q, ack_d;
   logic             pulse_q, pulse_d;
   logic             req_sync;

   // Saturating up/down count; a simultaneous increment and launch cancel out.
   function automatic logic [CNT_W-1:0] pend_next(input logic [CNT_W-1:0] pend,
                                                  input logic inc, input logic dec);
      if (inc && !dec) begin
         return (pend == PEND_MAX) ? pend : pend + CNT_W'(1);
      end
      if (dec && !inc) begin
         return pend - CNT_W'(1);
      end
      return pend;
   endfunction

   cdc_synczr #(.STAGES(SYNC_STG)) u_ack_sync (
      .clk_i   (clk_a_i),
      .rst_n_i (rst_a_n_i),
      .d_i     (ack_q),
      .q_o     (ack_sync)
   );

   cdc_synczr #(.STAGES(SYNC_STG)) u_req_sync (
      .clk_i   (clk_b_i),
      .rst_n_i (rst_b_n_i),
      .d_i     (req_q),
      .q_o     (req_sync)
   );

   always_comb begin
      tx_d   = tx_q;
      req_d  = req_q;
      launch = 1'b0;
      case (tx_q)
         TX_IDLE: begin
            if (pulse_i || (pend_q != '0)) begin
               launch = 1'b1;
               req_d  = 1'b1;
               tx_d   = TX_WAIT_ACK_H;
            end
         end
         TX_WAIT_ACK_H: begin
            if (ack_sync) begin
               req_d = 1'b0;
               tx_d  = TX_WAIT_ACK_L;
            end
         end
         TX_WAIT_ACK_L: begin
            // Handshake closes; back-to-back launch saves a cycle per queued event.
            if (!ack_sync) begin
               tx_d = TX_IDLE;
               if (pulse_i || (pend_q != '0)) begin
                  launch = 1'b1;
                  req_d  = 1'b1;
                  tx_d   = TX_WAIT_ACK_H;
               end
            end
         end
         default: begin
            tx_d  = TX_IDLE;
            req_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      pend_d = pend_next(pend_q, pulse_i, launch);
      ovf_d  = ovf_q;
      if (ovf_clr_i) begin
         ovf_d = 1'b0;
      end
      if (pulse_i && !launch && (pend_q == PEND_MAX)) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk_a_i or negedge rst_a_n_i) begin
      if (!rst_a_n_i) begin
         tx_q   <= TX_IDLE;
         req_q  <= 1'b0;
         pend_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         tx_q   <= tx_d;
         req_q  <= req_d;
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
      end
   end

   always_comb begin
      rx_d    = rx_q;
      ack_d   = ack_q;
      pulse_d = 1'b0;
      case (rx_q)
         RX_IDLE: begin
            if (req_sync) begin
               ack_d   = 1'b1;
               pulse_d = 1'b1;
               rx_d    = RX_WAIT_REQ_L;
            end
         end
         RX_WAIT_REQ_L: begin
            if (!req_sync) begin
               ack_d = 1'b0;
               rx_d  = RX_IDLE;
            end
         end
         default: begin
            ack_d = 1'b0;
            rx_d  = RX_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_b_i or negedge rst_b_n_i) begin
      if (!rst_b_n_i) begin
         rx_q    <= RX_IDLE;
         ack_q   <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         rx_q    <= rx_d;
         ack_q   <= ack_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse_o = pulse_q;
   assign busy_o  = (tx_q != TX_IDLE) || (pend_q != '0);
   assign ovf_o   = ovf_q;

endmodule

// File: rtl/pulse_deliver_mc.sv
// Multi-channel lossless pulse transfer from clk_a to clk_b; channels are
// fully independent replicas of pulse_deliver_ch.
module pulse_deliver_mc
   import pulse_deliver_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 4,
   parameter int SYNC_STG = 2
) (
   input  logic              clk_a,
   input  logic              rst_a_n,
   input  logic              clk_b,
   input  logic              rst_b_n,
   input  logic [NUM_CH-1:0] pulse_in,
   input  logic [NUM_CH-1:0] ovf_clr,
   output logic [NUM_CH-1:0] pulse_out,
   output logic [NUM_CH-1:0] busy_a,
   output logic [NUM_CH-1:0] ovf_a
);

   if ((SYNC_STG < SYNC_STG_MIN) || (SYNC_STG > SYNC_STG_MAX)) begin : g_bad_sync_stg
      $error("pulse_deliver_mc: SYNC_STG out of range");
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      pulse_deliver_ch #(
         .CNT_W    (CNT_W),
         .SYNC_STG (SYNC_STG)
      ) u_ch (
         .clk_a_i   (clk_a),
         .rst_a_n_i (rst_a_n),
         .clk_b_i   (clk_b),
         .rst_b_n_i (rst_b_n),
         .pulse_i   (pulse_in[i]),
         .ovf_clr_i (ovf_clr[i]),
         .pulse_o   (pulse_out[i]),
         .busy_o    (busy_a[i]),
         .ovf_o     (ovf_a[i])
      );
   end

endmodule

// File: tb/tb_pulse_deliver_mc.sv
// Scoreboard bench for pulse_deliver_mc: stimulus queues expected pulses per
// channel, a clk_b monitor consumes them and checks handshake spacing.
module tb_pulse_deliver_mc;
   import pulse_deliver_pkg::*;

   localparam int NUM_CH   = 4;
   localparam int CNT_W    = 4;
   localparam int SYNC_STG = 2;
   localparam int MIN_GAP  = 2 * SYNC_STG + 2;

   logic              clk_a, clk_b, rst_a_n, rst_b_n;
   logic [NUM_CH-1:0] pulse_in, ovf_clr, pulse_out, busy_a, ovf_a;

   // Half periods stay multiples of 5 and clk_b is offset by 2, so edges never coincide.
   int ha = 5;
   int hb = 15;
   int checks = 0;
   int errors = 0;
   int exp_q [NUM_CH][$];
   int seq [NUM_CH] = '{default: 0};
   int last_p [NUM_CH] = '{default: -1000};
   int bcyc = 0;
   int lat_n;
   logic lat_got;

   pulse_deliver_mc #(
      .NUM_CH   (NUM_CH),
      .CNT_W    (CNT_W),
      .SYNC_STG (SYNC_STG)
   ) dut (
      .clk_a     (clk_a),
      .rst_a_n   (rst_a_n),
      .clk_b     (clk_b),
      .rst_b_n   (rst_b_n),
      .pulse_in  (pulse_in),
      .ovf_clr   (ovf_clr),
      .pulse_out (pulse_out),
      .busy_a    (busy_a),
      .ovf_a     (ovf_a)
   );

   initial begin
      clk_a = 1'b0;
      forever #(ha) clk_a = ~clk_a;
   end

   initial begin
      clk_b = 1'b0;
      #2;
      forever #(hb) clk_b = ~clk_b;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic expect_n(input int c, input int n);
      for (int k = 0; k < n; k++) begin
         seq[c]++;
         exp_q[c].push_back(seq[c]);
      end
   endtask

   function automatic bit q_empty();
      for (int c = 0; c < NUM_CH; c++) begin
         if (exp_q[c].size() != 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic drain(input string nm, input int budget);
      int n;
      n = 0;
      while (((busy_a !== '0) || !q_empty()) && (n < budget)) begin
         @(posedge clk_a);
         #1;
         n++;
      end
      chk(nm, 32'((busy_a === '0) && q_empty()), 1);
      repeat (12) @(posedge clk_b);
   endtask

   always @(posedge clk_b) begin
      #1;
      bcyc++;
      for (int c = 0; c < NUM_CH; c++) begin
         if (pulse_out[c] === 1'b1) begin
            checks++;
            if (exp_q[c].size() == 0) begin
               errors++;
               $display("FAIL pulse_out[%0d]: got unexpected pulse, expected none queued", c);
            end else begin
               exp_q[c].delete(0);
            end
            checks++;
            if ((bcyc - last_p[c]) < MIN_GAP) begin
               errors++;
               $display("FAIL gap[%0d]: got %0d clk_b cycles, expected >= %0d",
                        c, bcyc - last_p[c], MIN_GAP);
            end
            last_p[c] = bcyc;
         end
      end
   end

   initial begin
      rst_a_n  = 1'b0;
      rst_b_n  = 1'b0;
      pulse_in = '0;
      ovf_clr  = '0;
      #40;
      chk("rst_pulse_out", 32'(pulse_out), 0);
      chk("rst_busy", 32'(busy_a), 0);
      chk("rst_ovf", 32'(ovf_a), 0);
      #11;
      rst_a_n = 1'b1;
      rst_b_n = 1'b1;
      repeat (3) @(posedge clk_a);
      #1;
      chk("idle_busy", 32'(busy_a), 0);
      chk("idle_tx0", 32'(dut.g_ch[0].u_ch.tx_q), 32'(TX_IDLE));

      // Single event on channel 0 with latency measurement.
      expect_n(0, 1);
      @(negedge clk_a);
      pulse_in = 4'b0001;
      @(posedge clk_a);
      #1;
      pulse_in = '0;
      chk("single_req", 32'(dut.g_ch[0].u_ch.req_q), 1);
      chk("single_busy", 32'(busy_a[0]), 1);
      lat_n   = 0;
      lat_got = 1'b0;
      while (!lat_got && (lat_n < 20)) begin
         @(posedge clk_b);
         #1;
         lat_n++;
         lat_got = pulse_out[0];
      end
      checks++;
      if (!lat_got || (lat_n < SYNC_STG + 1) || (lat_n > SYNC_STG + 2)) begin
         errors++;
         $display("FAIL single_latency: got %0d clk_b edges (seen=%0d), expected %0d..%0d",
                  lat_n, lat_got, SYNC_STG + 1, SYNC_STG + 2);
      end
      drain("single_drain", 500);

      // Burst of 5 on channel 1.
      expect_n(1, 5);
      @(negedge clk_a);
      pulse_in = 4'b0010;
      repeat (5) @(negedge clk_a);
      pulse_in = '0;
      drain("burst_drain", 1000);
      chk("burst_ovf", 32'(ovf_a[1]), 0);

      // Saturation on channel 2; clk_b slowed so no handshake completes inside the burst.
      hb = 25;
      repeat (4) @(posedge clk_b);
      expect_n(2, 16);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_a);
         pulse_in = 4'b0100;
         ovf_clr  = (i == 19) ? 4'b0100 : 4'b0000;
      end
      @(negedge clk_a);
      pulse_in = '0;
      ovf_clr  = '0;
      chk("sat_pend", 32'(dut.g_ch[2].u_ch.pend_q), 15);
      chk("sat_ovf_set_wins", 32'(ovf_a[2]), 1);
      chk("sat_busy", 32'(busy_a[2]), 1);
      @(negedge clk_a);
      ovf_clr = 4'b0100;
      @(negedge clk_a);
      ovf_clr = '0;
      chk("sat_ovf_clr", 32'(ovf_a[2]), 0);
      drain("sat_drain", 3000);
      chk("sat_ovf_final", 32'(ovf_a), 0);

      // Reset A with three pending events on channel 1, before RX can sample req.
      @(posedge clk_b);
      @(negedge clk_a);
      pulse_in = 4'b0010;
      repeat (4) @(negedge clk_a);
      pulse_in = '0;
      chk("rsta_pend", 32'(dut.g_ch[1].u_ch.pend_q), 3);
      rst_a_n = 1'b0;
      #1;
      chk("rsta_busy", 32'(busy_a), 0);
      chk("rsta_req", 32'(dut.g_ch[1].u_ch.req_q), 0);
      repeat (3) @(posedge clk_b);
      @(negedge clk_a);
      rst_a_n = 1'b1;
      repeat (20) @(posedge clk_b);
      #1;
      chk("rsta_busy_after", 32'(busy_a), 0);
      chk("rsta_rx_idle", 32'(dut.g_ch[1].u_ch.rx_q), 32'(RX_IDLE));

      // Reset B while channel 0 waits for ack.
      hb = 15;
      repeat (4) @(posedge clk_b);
      expect_n(0, 1);
      @(negedge clk_a);
      pulse_in = 4'b0001;
      @(posedge clk_a);
      #1;
      pulse_in = '0;
      rst_b_n  = 1'b0;
      repeat (6) @(posedge clk_a);
      #1;
      chk("rstb_tx_wait_h", 32'(dut.g_ch[0].u_ch.tx_q), 32'(TX_WAIT_ACK_H));
      chk("rstb_no_pulse", 32'(pulse_out), 0);
      @(negedge clk_b);
      rst_b_n = 1'b1;
      drain("rstb_drain", 1000);
      chk("rstb_tx_idle", 32'(dut.g_ch[0].u_ch.tx_q), 32'(TX_IDLE));

      // Illegal TX encoding on channel 3.
      @(negedge clk_a);
      force dut.g_ch[3].u_ch.tx_q = tx_state_e'(3'b011);
      #1;
      chk("illegal_next", 32'(dut.g_ch[3].u_ch.tx_d), 32'(TX_IDLE));
      chk("illegal_req_d", 32'(dut.g_ch[3].u_ch.req_d), 0);
      release dut.g_ch[3].u_ch.tx_q;
      @(posedge clk_a);
      #1;
      chk("illegal_tx", 32'(dut.g_ch[3].u_ch.tx_q), 32'(TX_IDLE));
      chk("illegal_req", 32'(dut.g_ch[3].u_ch.req_q), 0);

      // All channels at once, clk_a fast then clk_b fast.
      for (int m = 0; m < 2; m++) begin
         ha = (m == 0) ? 5 : 15;
         hb = (m == 0) ? 15 : 5;
         repeat (4) @(posedge clk_a);
         for (int c = 0; c < NUM_CH; c++) expect_n(c, 1);
         @(negedge clk_a);
         pulse_in = 4'b1111;
         @(negedge clk_a);
         pulse_in = '0;
         drain((m == 0) ? "simul_1to3_drain" : "simul_3to1_drain", 1000);
      end
      chk("final_ovf", 32'(ovf_a), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
